// File: rtl/fe_bf2ii_frame_arb.sv
// Frame-granular round-robin arbiter sharing one serial bf2ii butterfly between two channels.
// Grants whole frames and tags each pair with channel, twiddle phase and frame boundaries.
//   state | meaning
//   IDLE  | no grant; arbitrate on i_valid, ch != last wins a tie
//   G0    | ch0 owns the butterfly until its frame-end pair
//   G1    | ch1 owns the butterfly until its frame-end pair
module fe_bf2ii_frame_arb #(
    parameter int NBW_IN = 8,
    parameter int NFRM   = 16,
    parameter int NBW_FC = 4,
    parameter int NBW_C  = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_async,
    input  logic [1:0]                            i_valid,
    output logic [1:0]                            o_ready,
    input  logic signed [1:0][1:0][NBW_IN-1:0]    i_data0,
    input  logic signed [1:0][1:0][NBW_IN-1:0]    i_data1,
    output logic                                  o_bf_valid,
    output logic signed [1:0][1:0][NBW_IN-1:0]    o_bf_data,
    output logic [NBW_C-1:0]                      o_bf_cnt,
    output logic                                  o_bf_ch,
    output logic                                  o_bf_sof,
    output logic                                  o_bf_eof,
    output logic                                  o_busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_t;

    localparam logic [NBW_FC-1:0] PCNT_LAST = NBW_FC'(NFRM - 1);

    state_t            state;
    state_t            state_nxt;
    logic [NBW_FC-1:0] pcnt;
    logic              last;
    logic              grant_ch;
    logic              xfer;
    logic              frame_end;

    assign grant_ch  = (state == G1);
    assign xfer      = |(i_valid & o_ready);
    assign frame_end = xfer && (pcnt == PCNT_LAST);

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame-end arbitration looks at same-cycle i_valid so a waiting channel switches in with no bubble.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                case (i_valid)
                    2'b01:   state_nxt = G0;
                    2'b10:   state_nxt = G1;
                    2'b11:   state_nxt = last ? G0 : G1;
                    default: state_nxt = IDLE;
                endcase
            end
            G0: begin
                if (frame_end) begin
                    if (i_valid[1])      state_nxt = G1;
                    else if (i_valid[0]) state_nxt = G0;
                    else                 state_nxt = IDLE;
                end
            end
            G1: begin
                if (frame_end) begin
                    if (i_valid[0])      state_nxt = G0;
                    else if (i_valid[1]) state_nxt = G1;
                    else                 state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_ready = 2'b00;
        case (state)
            G0:      o_ready = 2'b01;
            G1:      o_ready = 2'b10;
            default: o_ready = 2'b00;
        endcase
        o_busy = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            pcnt <= '0;
            last <= 1'b1;
        end else if (xfer) begin
            if (frame_end) begin
                pcnt <= '0;
                last <= grant_ch;
            end else begin
                pcnt <= pcnt + NBW_FC'(1);
            end
        end
    end

    // Data, phase and channel hold through bubbles; frame markers are single-pulse.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            o_bf_valid <= 1'b0;
            o_bf_data  <= '0;
            o_bf_cnt   <= '0;
            o_bf_ch    <= 1'b0;
            o_bf_sof   <= 1'b0;
            o_bf_eof   <= 1'b0;
        end else begin
            o_bf_valid <= xfer;
            if (xfer) begin
                o_bf_data <= grant_ch ? i_data1 : i_data0;
                o_bf_cnt  <= pcnt[NBW_C-1:0];
                o_bf_ch   <= grant_ch;
                o_bf_sof  <= (pcnt == '0);
                o_bf_eof  <= (pcnt == PCNT_LAST);
            end else begin
                o_bf_sof  <= 1'b0;
                o_bf_eof  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fe_bf2ii_frame_arb.sv
// Bench for fe_bf2ii_frame_arb: phase table plus hand sequences, with a reference model
// feeding a scoreboard of expected butterfly-side transfers.
module tb_fe_bf2ii_frame_arb;
    localparam int NBW_IN = 8;
    localparam int NFRM   = 16;
    localparam int NBW_FC = 4;
    localparam int NBW_C  = 2;

    logic                         clk = 1'b0;
    logic                         rst_async = 1'b0;
    logic [1:0]                   i_valid = 2'b00;
    logic [1:0]                   o_ready;
    logic [1:0][1:0][NBW_IN-1:0]  i_data0 = '0;
    logic [1:0][1:0][NBW_IN-1:0]  i_data1 = '0;
    logic                         o_bf_valid;
    logic [1:0][1:0][NBW_IN-1:0]  o_bf_data;
    logic [NBW_C-1:0]             o_bf_cnt;
    logic                         o_bf_ch;
    logic                         o_bf_sof;
    logic                         o_bf_eof;
    logic                         o_busy;

    fe_bf2ii_frame_arb #(.NBW_IN(NBW_IN), .NFRM(NFRM), .NBW_FC(NBW_FC), .NBW_C(NBW_C)) dut (
        .clk(clk), .rst_async(rst_async), .i_valid(i_valid), .o_ready(o_ready),
        .i_data0(i_data0), .i_data1(i_data1), .o_bf_valid(o_bf_valid), .o_bf_data(o_bf_data),
        .o_bf_cnt(o_bf_cnt), .o_bf_ch(o_bf_ch), .o_bf_sof(o_bf_sof), .o_bf_eof(o_bf_eof),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  cnt;
        logic        ch;
        logic        sof;
        logic        eof;
    } exp_t;

    typedef struct {
        logic [1:0] valid;
        int         n;
        logic [1:0] ready;
        logic       busy;
        int         nvalid;
    } vec_t;

    exp_t        sb[$];
    vec_t        tbl[7];
    int          checks = 0;
    int          failures = 0;
    int          mstate = 0;
    int          mcnt = 0;
    logic        mlast = 1'b1;
    int          nval = 0;
    logic [31:0] hold_data = '0;
    logic [1:0]  hold_cnt = '0;
    logic        hold_ch = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mstate = 0;
        mcnt = 0;
        mlast = 1'b1;
        sb.delete();
        hold_data = '0;
        hold_cnt = '0;
        hold_ch = 1'b0;
    endtask

    task automatic check_outputs();
        exp_t e;
        if (o_bf_valid) begin
            nval++;
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'(o_bf_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("data", o_bf_data, e.data);
                chk("cnt", 32'(o_bf_cnt), 32'(e.cnt));
                chk("ch", 32'(o_bf_ch), 32'(e.ch));
                chk("sof", 32'(o_bf_sof), 32'(e.sof));
                chk("eof", 32'(o_bf_eof), 32'(e.eof));
                hold_data = e.data;
                hold_cnt = e.cnt;
                hold_ch = e.ch;
            end
        end else begin
            chk("missing_valid", 32'(sb.size()), 32'd0);
            if (sb.size() != 0) void'(sb.pop_front());
            chk("sof_idle", 32'(o_bf_sof), 32'd0);
            chk("eof_idle", 32'(o_bf_eof), 32'd0);
            chk("hold_data", o_bf_data, hold_data);
            chk("hold_cnt", 32'(o_bf_cnt), 32'(hold_cnt));
            chk("hold_ch", 32'(o_bf_ch), 32'(hold_ch));
        end
    endtask

    // Called one time unit after a rising edge; returns one time unit after the next.
    task automatic cycle(input logic [1:0] v);
        logic       g;
        logic       mx;
        logic [1:0] er;
        exp_t       e;
        i_valid = v;
        i_data0 = $urandom;
        i_data1 = $urandom;
        #1;
        er = (mstate == 1) ? 2'b01 : (mstate == 2) ? 2'b10 : 2'b00;
        chk("ready", 32'(o_ready), 32'(er));
        chk("busy", 32'(o_busy), 32'(mstate != 0));
        g  = (mstate == 2);
        mx = (mstate != 0) && v[g];
        if (mx) begin
            e.data = g ? i_data1 : i_data0;
            e.cnt  = 2'(mcnt);
            e.ch   = g;
            e.sof  = (mcnt == 0);
            e.eof  = (mcnt == NFRM - 1);
            sb.push_back(e);
        end
        if (mstate == 0) begin
            if (v == 2'b01)      mstate = 1;
            else if (v == 2'b10) mstate = 2;
            else if (v == 2'b11) mstate = mlast ? 1 : 2;
        end else if (mx) begin
            if (mcnt == NFRM - 1) begin
                mcnt = 0;
                mlast = g;
                if (v[!g])      mstate = g ? 1 : 2;
                else if (!v[g]) mstate = 0;
            end else begin
                mcnt++;
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst_async = 1'b1;
        i_valid = 2'b00;
        @(posedge clk);
        #1;
        chk("rst_valid", 32'(o_bf_valid), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_data", o_bf_data, 32'd0);
        chk("rst_cnt", 32'(o_bf_cnt), 32'd0);
        chk("rst_flags", {29'd0, o_bf_ch, o_bf_sof, o_bf_eof}, 32'd0);
        @(posedge clk);
        #1;
        rst_async = 1'b0;
        model_reset();
    endtask

    initial begin
        int n0;
        tbl[0] = '{valid: 2'b01, n: 1,  ready: 2'b01, busy: 1'b1, nvalid: 0};
        tbl[1] = '{valid: 2'b01, n: 16, ready: 2'b01, busy: 1'b1, nvalid: 16};
        tbl[2] = '{valid: 2'b00, n: 3,  ready: 2'b01, busy: 1'b1, nvalid: 0};
        tbl[3] = '{valid: 2'b11, n: 16, ready: 2'b10, busy: 1'b1, nvalid: 16};
        tbl[4] = '{valid: 2'b11, n: 16, ready: 2'b01, busy: 1'b1, nvalid: 16};
        tbl[5] = '{valid: 2'b11, n: 16, ready: 2'b10, busy: 1'b1, nvalid: 16};
        tbl[6] = '{valid: 2'b11, n: 16, ready: 2'b01, busy: 1'b1, nvalid: 16};

        do_reset();

        for (int i = 0; i < 7; i++) begin
            n0 = nval;
            for (int k = 0; k < tbl[i].n; k++) cycle(tbl[i].valid);
            chk($sformatf("tbl%0d_ready", i), 32'(o_ready), 32'(tbl[i].ready));
            chk($sformatf("tbl%0d_busy", i), 32'(o_busy), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_nvalid", i), 32'(nval - n0), 32'(tbl[i].nvalid));
        end

        // ch0 stalls at pair 5 while ch1 waits
        repeat (5) cycle(2'b01);
        n0 = nval;
        repeat (3) begin
            cycle(2'b10);
            chk("t3_ready_held", 32'(o_ready), 32'(2'b01));
        end
        chk("t3_bubbles", 32'(nval - n0), 32'd0);
        cycle(2'b01);
        cycle(2'b01);
        chk("t3_valid", 32'(o_bf_valid), 32'd1);
        chk("t3_cnt", 32'(o_bf_cnt), 32'd2);
        chk("t3_sof", 32'(o_bf_sof), 32'd0);

        // ch1 requests at ch0 pair 7; switch only after pair 15
        repeat (9) cycle(2'b11);
        chk("t4_eof", 32'(o_bf_eof), 32'd1);
        chk("t4_last_ch", 32'(o_bf_ch), 32'd0);
        chk("t4_ready", 32'(o_ready), 32'(2'b10));
        cycle(2'b10);
        chk("t4_ch", 32'(o_bf_ch), 32'd1);
        chk("t4_sof", 32'(o_bf_sof), 32'd1);
        chk("t4_cnt", 32'(o_bf_cnt), 32'd0);

        // reset in the middle of a ch0 frame
        repeat (15) cycle(2'b11);
        chk("t5_ready_g0", 32'(o_ready), 32'(2'b01));
        repeat (9) cycle(2'b01);
        i_valid = 2'b01;
        #2;
        rst_async = 1'b1;
        #1;
        chk("t5_valid_now", 32'(o_bf_valid), 32'd0);
        chk("t5_ready_now", 32'(o_ready), 32'd0);
        chk("t5_busy_now", 32'(o_busy), 32'd0);
        @(posedge clk);
        #1;
        rst_async = 1'b0;
        model_reset();
        cycle(2'b11);
        cycle(2'b11);
        chk("t5_ch", 32'(o_bf_ch), 32'd0);
        chk("t5_sof", 32'(o_bf_sof), 32'd1);
        chk("t5_cnt", 32'(o_bf_cnt), 32'd0);

        // idle, then a lone ch1 request
        do_reset();
        repeat (2) cycle(2'b00);
        chk("t6_busy", 32'(o_busy), 32'd0);
        chk("t6_ready", 32'(o_ready), 32'd0);
        cycle(2'b10);
        chk("t6_bubble", 32'(o_bf_valid), 32'd0);
        chk("t6_ready_g1", 32'(o_ready), 32'(2'b10));
        cycle(2'b10);
        chk("t6_ch", 32'(o_bf_ch), 32'd1);
        chk("t6_sof", 32'(o_bf_sof), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
